// File: rtl/axi_wr_slave_resp.sv
// AXI3 write-channel responder.
// Accepts one AW request at a time and then its W beats. Each beat is
// presented on a registered backend write port, and the beat address
// follows FIXED, INCR or WRAP address generation. A B response carrying
// the captured ID and user bits is returned after the last beat.
module axi_wr_slave_resp #(
  parameter int PID_WIDTH     = 4,
  parameter int PADDR_WIDTH   = 32,
  parameter int PLENGTH_WIDTH = 3,
  parameter int PSIZE_WIDTH   = 2,
  parameter int PAWUSER_WIDTH = 2,
  parameter int PDATA_WIDTH   = 128,
  parameter int PSTRB_WIDTH   = PDATA_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [PID_WIDTH-1:0]     awid,
  input  logic [PADDR_WIDTH-1:0]   awaddr,
  input  logic [PLENGTH_WIDTH-1:0] awlen,
  input  logic [PSIZE_WIDTH-1:0]   awsize,
  input  logic [1:0]               awburst,
  input  logic [PAWUSER_WIDTH-1:0] awuser,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [PDATA_WIDTH-1:0]   wdata,
  input  logic [PSTRB_WIDTH-1:0]   wstrb,
  input  logic                     wlast,
  output logic                     bvalid,
  input  logic                     bready,
  output logic [PID_WIDTH-1:0]     bid,
  output logic [1:0]               bresp,
  output logic [PAWUSER_WIDTH-1:0] buser,
  output logic                     mem_we,
  output logic [PADDR_WIDTH-1:0]   mem_addr,
  output logic [PDATA_WIDTH-1:0]   mem_data,
  output logic [PSTRB_WIDTH-1:0]   mem_strb
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_RESP
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Beat counter is one bit wider than awlen so it can saturate at 2**PLENGTH_WIDTH.
  localparam logic [PLENGTH_WIDTH:0] CNT_MAX = {1'b1, {PLENGTH_WIDTH{1'b0}}};
  localparam logic [PLENGTH_WIDTH:0] CNT_ONE = (PLENGTH_WIDTH+1)'(1);

  state_t                   state;
  logic [PID_WIDTH-1:0]     cap_id;
  logic [PLENGTH_WIDTH-1:0] cap_len;
  logic [PSIZE_WIDTH-1:0]   cap_size;
  logic [1:0]               cap_burst;
  logic [PAWUSER_WIDTH-1:0] cap_user;
  logic [PADDR_WIDTH-1:0]   cur_addr;
  logic [PLENGTH_WIDTH:0]   beat_cnt;
  logic                     err;

  logic                     aw_fire;
  logic                     w_fire;
  logic                     b_fire;
  logic                     req_err;
  logic [PADDR_WIDTH-1:0]   in_bytes;
  logic [PLENGTH_WIDTH:0]   len_ext;
  logic [PLENGTH_WIDTH:0]   len_plus1;
  logic [PADDR_WIDTH-1:0]   beat_bytes;
  logic [PADDR_WIDTH-1:0]   wrap_mask;
  logic [PADDR_WIDTH-1:0]   addr_inc;
  logic [PADDR_WIDTH-1:0]   next_addr;
  logic                     early_last;
  logic                     missing_last;
  logic                     err_next;
  logic                     beat_over;

  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;
  assign b_fire  = bvalid & bready;

  // Request-level error check on the incoming AW fields, evaluated at capture.
  always_comb begin
    in_bytes = PADDR_WIDTH'(1) << awsize;
    req_err  = 1'b0;
    if (awburst == 2'b11) begin
      req_err = 1'b1;
    end else if (awburst == BURST_WRAP) begin
      if (!((awlen == PLENGTH_WIDTH'(1)) || (awlen == PLENGTH_WIDTH'(3)) ||
            (awlen == PLENGTH_WIDTH'(7)))) begin
        req_err = 1'b1;
      end
      if ((awaddr & (in_bytes - PADDR_WIDTH'(1))) != '0) begin
        req_err = 1'b1;
      end
    end
  end

  // Next beat address and per-beat protocol error detection.
  always_comb begin
    len_ext    = {1'b0, cap_len};
    len_plus1  = len_ext + CNT_ONE;
    beat_bytes = PADDR_WIDTH'(1) << cap_size;
    wrap_mask  = (PADDR_WIDTH'(len_plus1) << cap_size) - PADDR_WIDTH'(1);
    addr_inc   = cur_addr + beat_bytes;
    case (cap_burst)
      BURST_FIXED: next_addr = cur_addr;
      BURST_INCR:  next_addr = addr_inc;
      BURST_WRAP:  next_addr = (cur_addr & ~wrap_mask) | (addr_inc & wrap_mask);
      default:     next_addr = cur_addr;
    endcase
    early_last   = wlast && (beat_cnt < len_ext);
    missing_last = !wlast && (beat_cnt == len_ext);
    err_next     = err | early_last | missing_last;
    beat_over    = beat_cnt > len_ext;
  end

  // Control FSM with registered handshake, response and backend outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      awready   <= 1'b1;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bid       <= '0;
      bresp     <= '0;
      buser     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_strb  <= '0;
      cap_id    <= '0;
      cap_len   <= '0;
      cap_size  <= '0;
      cap_burst <= '0;
      cap_user  <= '0;
      cur_addr  <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (aw_fire) begin
            cap_id    <= awid;
            cap_len   <= awlen;
            cap_size  <= awsize;
            cap_burst <= awburst;
            cap_user  <= awuser;
            cur_addr  <= awaddr;
            err       <= req_err;
            beat_cnt  <= '0;
            awready   <= 1'b0;
            wready    <= 1'b1;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_fire) begin
            // Strobe gating uses the error state from before this beat, so the
            // beat that reveals a wlast mismatch is itself still written.
            mem_we   <= 1'b1;
            mem_addr <= cur_addr;
            mem_data <= wdata;
            mem_strb <= (err || beat_over) ? '0 : wstrb;
            cur_addr <= next_addr;
            err      <= err_next;
            if (beat_cnt != CNT_MAX) begin
              beat_cnt <= beat_cnt + CNT_ONE;
            end
            if (wlast) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= cap_id;
              buser  <= cap_user;
              bresp  <= err_next ? RESP_SLVERR : RESP_OKAY;
              state  <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (b_fire) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          awready <= 1'b1;
          wready  <= 1'b0;
          bvalid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_slave_resp.sv
// Directed bench for axi_wr_slave_resp: bursts of each type, wlast errors,
// B backpressure and reset in the middle of a burst.
module tb_axi_wr_slave_resp;

  logic         clk;
  logic         resetn;
  logic         awvalid;
  logic         awready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [2:0]   awlen;
  logic [1:0]   awsize;
  logic [1:0]   awburst;
  logic [1:0]   awuser;
  logic         wvalid;
  logic         wready;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast;
  logic         bvalid;
  logic         bready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic [1:0]   buser;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_data;
  logic [15:0]  mem_strb;

  axi_wr_slave_resp #(
    .PID_WIDTH     (4),
    .PADDR_WIDTH   (32),
    .PLENGTH_WIDTH (3),
    .PSIZE_WIDTH   (2),
    .PAWUSER_WIDTH (2),
    .PDATA_WIDTH   (128),
    .PSTRB_WIDTH   (16)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .awvalid  (awvalid),
    .awready  (awready),
    .awid     (awid),
    .awaddr   (awaddr),
    .awlen    (awlen),
    .awsize   (awsize),
    .awburst  (awburst),
    .awuser   (awuser),
    .wvalid   (wvalid),
    .wready   (wready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .bvalid   (bvalid),
    .bready   (bready),
    .bid      (bid),
    .bresp    (bresp),
    .buser    (buser),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_strb (mem_strb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0]  wr_addr_q[$];
  logic [15:0]  wr_strb_q[$];
  logic [127:0] wr_data_q[$];
  logic [31:0]  exp_a[8];
  logic [15:0]  exp_s[8];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] data_for(input int i);
    return {96'h0, 32'hD0D0_0000 | 32'(i)};
  endfunction

  function automatic logic [15:0] strb_for(input int i);
    logic [15:0] base;
    base = 16'h1111;
    return base << i;
  endfunction

  // Log every backend write, sampled on the falling edge.
  always @(negedge clk) begin
    if (resetn && mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_strb_q.push_back(mem_strb);
      wr_data_q.push_back(mem_data);
    end
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_strb_q.delete();
    wr_data_q.delete();
  endtask

  task automatic set_aw(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] len,
                        input logic [1:0] size, input logic [1:0] burst, input logic [1:0] user);
    awid    = id;
    awaddr  = addr;
    awlen   = len;
    awsize  = size;
    awburst = burst;
    awuser  = user;
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] len,
                       input logic [1:0] size, input logic [1:0] burst, input logic [1:0] user);
    set_aw(id, addr, len, size, burst, user);
    awvalid = 1'b1;
    for (int i = 0; i < 20 && !awready; i++) @(negedge clk);
    check_val("aw_accept", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    check_val("wready_after_aw", wready, 1);
  endtask

  task automatic send_beat(input int i, input logic last);
    wvalid = 1'b1;
    wdata  = data_for(i);
    wstrb  = strb_for(i);
    wlast  = last;
    for (int k = 0; k < 20 && !wready; k++) @(negedge clk);
    check_val("w_accept", wready, 1);
    @(negedge clk);
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] len,
                          input logic [1:0] size, input logic [1:0] burst, input logic [1:0] user,
                          input int nbeats);
    do_aw(id, addr, len, size, burst, user);
    for (int i = 0; i < nbeats; i++) send_beat(i, i == nbeats - 1);
    check_val("bvalid_latency", bvalid, 1);
    check_val("last_we_with_b", mem_we, 1);
  endtask

  task automatic take_b(input logic [3:0] eid, input logic [1:0] eresp, input logic [1:0] euser);
    check_val("bid", bid, eid);
    check_val("bresp", bresp, eresp);
    check_val("buser", buser, euser);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check_val("bvalid_cleared", bvalid, 0);
    check_val("awready_after_b", awready, 1);
    check_val("wready_idle", wready, 0);
  endtask

  task automatic check_writes(input int n, input bit chk_addr);
    check_val("we_count", wr_addr_q.size(), n);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      if (chk_addr) check_val($sformatf("addr%0d", i), wr_addr_q[i], exp_a[i]);
      check_val($sformatf("strb%0d", i), wr_strb_q[i], exp_s[i]);
      check_val($sformatf("data%0d", i), wr_data_q[i], data_for(i));
    end
    clear_log();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_awready"}, awready, 1);
    check_val({tag, "_wready"}, wready, 0);
    check_val({tag, "_bvalid"}, bvalid, 0);
    check_val({tag, "_mem_we"}, mem_we, 0);
    check_val({tag, "_bid"}, bid, 0);
    check_val({tag, "_bresp"}, bresp, 0);
    check_val({tag, "_buser"}, buser, 0);
    check_val({tag, "_mem_addr"}, mem_addr, 0);
    check_val({tag, "_mem_data"}, mem_data, 0);
    check_val({tag, "_mem_strb"}, mem_strb, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wlast   = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    bready  = 1'b0;
    set_aw(4'd0, 32'd0, 3'd0, 2'd0, 2'd0, 2'd0);
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    resetn = 1'b1;
    @(negedge clk);

    // INCR, 4 beats of 4 bytes
    do_burst(4'd5, 32'h100, 3'd3, 2'd2, 2'b01, 2'd2, 4);
    take_b(4'd5, 2'b00, 2'd2);
    exp_a[0] = 32'h100; exp_a[1] = 32'h104; exp_a[2] = 32'h108; exp_a[3] = 32'h10C;
    for (int i = 0; i < 4; i++) exp_s[i] = strb_for(i);
    check_writes(4, 1'b1);

    // WRAP within a 16-byte boundary
    do_burst(4'd6, 32'h10C, 3'd3, 2'd2, 2'b10, 2'd1, 4);
    take_b(4'd6, 2'b00, 2'd1);
    exp_a[0] = 32'h10C; exp_a[1] = 32'h100; exp_a[2] = 32'h104; exp_a[3] = 32'h108;
    check_writes(4, 1'b1);

    // FIXED, 3 beats
    do_burst(4'd7, 32'h40, 3'd2, 2'd2, 2'b00, 2'd0, 3);
    take_b(4'd7, 2'b00, 2'd0);
    for (int i = 0; i < 3; i++) exp_a[i] = 32'h40;
    check_writes(3, 1'b1);

    // Early wlast on beat 1 of a 4-beat burst
    do_burst(4'd8, 32'h200, 3'd3, 2'd2, 2'b01, 2'd0, 2);
    take_b(4'd8, 2'b10, 2'd0);
    exp_a[0] = 32'h200; exp_a[1] = 32'h204;
    check_writes(2, 1'b1);

    // Missing wlast: awlen=1 but wlast only on beat 3
    do_burst(4'd9, 32'h300, 3'd1, 2'd2, 2'b01, 2'd3, 4);
    take_b(4'd9, 2'b10, 2'd3);
    exp_a[0] = 32'h300; exp_a[1] = 32'h304; exp_a[2] = 32'h308; exp_a[3] = 32'h30C;
    exp_s[0] = strb_for(0); exp_s[1] = strb_for(1); exp_s[2] = '0; exp_s[3] = '0;
    check_writes(4, 1'b1);

    // Reserved burst type: all writes suppressed
    do_burst(4'd10, 32'h400, 3'd1, 2'd2, 2'b11, 2'd1, 2);
    take_b(4'd10, 2'b10, 2'd1);
    exp_s[0] = '0; exp_s[1] = '0;
    check_writes(2, 1'b0);

    // WRAP with an illegal length (3 beats)
    do_burst(4'd3, 32'h500, 3'd2, 2'd2, 2'b10, 2'd0, 3);
    take_b(4'd3, 2'b10, 2'd0);
    exp_s[2] = '0;
    check_writes(3, 1'b0);

    // B backpressure with a new AW waiting
    do_burst(4'd11, 32'h500, 3'd0, 2'd2, 2'b01, 2'd1, 1);
    set_aw(4'd12, 32'h600, 3'd1, 2'd2, 2'b01, 2'd2);
    awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("bp_bvalid%0d", i), bvalid, 1);
      check_val($sformatf("bp_bid%0d", i), bid, 4'd11);
      check_val($sformatf("bp_bresp%0d", i), bresp, 2'b00);
      check_val($sformatf("bp_awready%0d", i), awready, 0);
      check_val($sformatf("bp_wready%0d", i), wready, 0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check_val("bp_bvalid_done", bvalid, 0);
    check_val("bp_awready_next", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    check_val("bp_aw_taken", awready, 0);
    check_val("bp_wready", wready, 1);
    exp_a[0] = 32'h500; exp_s[0] = strb_for(0);
    check_writes(1, 1'b1);
    send_beat(0, 1'b0);
    send_beat(1, 1'b1);
    check_val("bp2_bvalid", bvalid, 1);
    take_b(4'd12, 2'b00, 2'd2);
    exp_a[0] = 32'h600; exp_a[1] = 32'h604;
    exp_s[0] = strb_for(0); exp_s[1] = strb_for(1);
    check_writes(2, 1'b1);

    // Reset after beat 1 of a 4-beat INCR
    do_aw(4'd13, 32'h700, 3'd3, 2'd2, 2'b01, 2'd0);
    send_beat(0, 1'b0);
    send_beat(1, 1'b0);
    resetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    check_val("midrst_no_b", bvalid, 0);
    resetn = 1'b1;
    @(negedge clk);
    clear_log();
    do_burst(4'd14, 32'h800, 3'd1, 2'd2, 2'b01, 2'd3, 2);
    take_b(4'd14, 2'b00, 2'd3);
    exp_a[0] = 32'h800; exp_a[1] = 32'h804;
    check_writes(2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_wr_slave_resp.md
Name: axi_wr_slave_resp

Overview:
- AXI3 write-channel responder (slave end) for the bursts the speculative master side issues.
- Accepts one AW request, then its W beats. Each beat goes to a simple backend memory write port with AXI-correct address generation (FIXED/INCR/WRAP).
- Returns a B response with the matching ID.
- One outstanding transaction; sits between the interconnect and the memory model / target.

Parameters:
- PID_WIDTH, 4, AWID/BID width
- PADDR_WIDTH, 32, address width
- PLENGTH_WIDTH, 3, AWLEN width (burst beats = awlen+1, max 8)
- PSIZE_WIDTH, 2, AWSIZE width (beat bytes = 2**awsize, max 8)
- PAWUSER_WIDTH, 2, AWUSER width
- PDATA_WIDTH, 128, W data bus width in bits
- PSTRB_WIDTH, PDATA_WIDTH/8, WSTRB width

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- awid  in  PID_WIDTH  write ID
- awaddr  in  PADDR_WIDTH  start address
- awlen  in  PLENGTH_WIDTH  beats-1
- awsize  in  PSIZE_WIDTH  log2 beat bytes
- awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- awuser  in  PAWUSER_WIDTH  transaction type, passed to buser
- wvalid  in  1  W valid
- wready  out  1  W ready
- wdata  in  PDATA_WIDTH  beat data
- wstrb  in  PSTRB_WIDTH  byte strobes
- wlast  in  1  last beat marker
- bvalid  out  1  B valid
- bready  in  1  B ready
- bid  out  PID_WIDTH  echoed awid
- bresp  out  2  00 OKAY, 10 SLVERR
- buser  out  PAWUSER_WIDTH  echoed awuser
- mem_we  out  1  backend write strobe, one cycle per accepted beat
- mem_addr  out  PADDR_WIDTH  beat address
- mem_data  out  PDATA_WIDTH  registered wdata
- mem_strb  out  PSTRB_WIDTH  registered wstrb (all-zero when error suppresses write)

Behaviour:
- Reset (async assert, sync release): state IDLE. awready=1. wready, bvalid, mem_we = 0. bid, bresp, buser, mem_addr, mem_data, mem_strb = 0. Beat counter = 0.
- FSM: IDLE -> DATA -> RESP -> IDLE.
- IDLE: awready=1, wready=0. On awvalid&awready, capture id, addr, len, size, burst, user; clear err flag; beat count=0; go to DATA.
- Request error, set at capture: awburst=11, or WRAP with awlen not in {1,3,7}, or WRAP with awaddr not aligned to 2**awsize.
- DATA: awready=0, wready=1. On each wvalid&wready:
  - Next cycle: mem_we=1, mem_addr=current beat address, mem_data/mem_strb = captured beat. mem_strb is forced to 0 if the err flag is set or the beat index > awlen.
  - Address update, with B = 2**awsize. FIXED: unchanged. INCR: addr+B (wraps modulo 2**PADDR_WIDTH). WRAP: lower bits wrap within a boundary of (awlen+1)*B bytes, i.e. addr = (addr & ~(L-1)) | ((addr+B) & (L-1)), L = (awlen+1)*B.
  - Beat count increments, saturating at 2**PLENGTH_WIDTH.
  - Early wlast (beat index < awlen): set err; burst ends.
  - Beat at index awlen without wlast: set err; stay in DATA absorbing beats (mem_strb=0) until wlast.
  - wlast accepted: go to RESP.
- RESP: bvalid=1 from the cycle after the wlast handshake, i.e. same cycle as the last mem_we. bid/buser = captured values; bresp = err ? 10 : 00. bvalid, bid, bresp, buser stay stable until bready. On bvalid&bready: bvalid=0, go to IDLE; awready=1 the next cycle (no AW/B overlap).
- wready=0 outside DATA. W beats arriving before AW are stalled, not dropped.
- Reset mid-burst: all state is discarded immediately; no B is issued for the aborted burst.
- Latency: AW accept -> earliest W accept is 1 cycle. Last W accept -> bvalid is 1 cycle.

Test Plan:
- INCR: awaddr=0x100, awlen=3, awsize=2, awid=5, awuser=2, 4 beats, last with wlast -> mem_addr 0x100, 0x104, 0x108, 0x10C, strobes passed through; bvalid 1 cycle after last beat with bid=5, bresp=00, buser=2.
- WRAP: awaddr=0x10C, awlen=3, awsize=2 -> mem_addr 0x10C, 0x100, 0x104, 0x108; bresp=00. FIXED: awaddr=0x40, awlen=2 -> 0x40 three times.
- Early wlast on beat 1 of awlen=3 -> 2 mem_we pulses, bresp=10, FSM back to IDLE after bready.
- Missing wlast: awlen=1, wlast on beat 3 -> 4 mem_we pulses, beats 2-3 with mem_strb=0; bresp=10. Separately, awburst=11 -> all mem_strb=0, bresp=10.
- Backpressure: hold bready=0 for 5 cycles -> bvalid, bid, bresp stable; awready=0 and wready=0 throughout; AW accepted only the cycle after bready.
- Assert resetn=0 after beat 1 of a 4-beat INCR -> outputs at reset values immediately; after release, a new burst completes normally with the correct bid.
